// File: rtl/ofdm_sync_controller_if.sv
// Handshake bundle between the OFDM sync controller and its environment.
// The master side drives control and symbol-sync status; the slave side is the controller.
interface ofdm_sync_controller_if;
  logic        ctrl_start;
  logic        ctrl_abort;
  logic        sync_pre_sampling;
  logic        sync_valid;
  logic        sync_endofpacket;
  logic        sync_enable;
  logic        sync_rearm;
  logic        frame_active;
  logic [7:0]  symbol_count;
  logic        frame_done;
  logic        timeout_err;
  logic [2:0]  ctrl_state;
  logic [15:0] stat_frames;
  logic [15:0] stat_timeouts;

  modport master (
    output ctrl_start, ctrl_abort, sync_pre_sampling, sync_valid, sync_endofpacket,
    input  sync_enable, sync_rearm, frame_active, symbol_count, frame_done,
           timeout_err, ctrl_state, stat_frames, stat_timeouts
  );

  modport slave (
    input  ctrl_start, ctrl_abort, sync_pre_sampling, sync_valid, sync_endofpacket,
    output sync_enable, sync_rearm, frame_active, symbol_count, frame_done,
           timeout_err, ctrl_state, stat_frames, stat_timeouts
  );
endinterface

// File: rtl/ofdm_sync_controller.sv
// Frame acquisition controller sequencing symbol search, capture and holdoff.
// Optional statistics counters are built only when SYNC_CTRL_STATS_EN is defined.
module ofdm_sync_controller #(
  parameter int SYMBOLS_PER_FRAME = 16,
  parameter int SEARCH_TIMEOUT    = 4096,
  parameter int CAPTURE_TIMEOUT   = 1024,
  parameter int HOLDOFF_CYCLES    = 8
) (
  input logic                   clock_clk,
  input logic                   reset_reset_n,
  ofdm_sync_controller_if.slave bus
);

  localparam int MAX_SC    = (SEARCH_TIMEOUT > CAPTURE_TIMEOUT) ? SEARCH_TIMEOUT : CAPTURE_TIMEOUT;
  localparam int TIMER_MAX = (MAX_SC > HOLDOFF_CYCLES) ? MAX_SC : HOLDOFF_CYCLES;
  localparam int TIMER_W   = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;

  localparam logic [TIMER_W-1:0] SEARCH_LAST  = TIMER_W'(SEARCH_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] CAPTURE_LAST = TIMER_W'(CAPTURE_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] HOLDOFF_LAST = TIMER_W'(HOLDOFF_CYCLES - 1);
  localparam logic [7:0]         FRAME_LEN    = 8'(SYMBOLS_PER_FRAME);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEARCH  = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_HOLDOFF = 3'd3
  } state_t;

  state_t             state, state_next;
  logic [TIMER_W-1:0] timer, timer_next;
  logic [7:0]         count, count_next;
  logic               rearm_next, done_next, timeout_next;

  logic sync_enable_q, frame_active_q, sync_rearm_q, frame_done_q, timeout_err_q;

  always_ff @(posedge clock_clk) begin
    if (!reset_reset_n) begin
      state          <= ST_IDLE;
      timer          <= '0;
      count          <= '0;
      sync_enable_q  <= 1'b0;
      frame_active_q <= 1'b0;
      sync_rearm_q   <= 1'b0;
      frame_done_q   <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      state          <= state_next;
      timer          <= timer_next;
      count          <= count_next;
      sync_enable_q  <= (state_next == ST_SEARCH) || (state_next == ST_CAPTURE);
      frame_active_q <= (state_next == ST_SEARCH) || (state_next == ST_CAPTURE);
      sync_rearm_q   <= rearm_next;
      frame_done_q   <= done_next;
      timeout_err_q  <= timeout_next;
    end
  end

  // Abort overrides everything; end-of-packet beats a coincident capture timeout.
  always_comb begin
    state_next   = state;
    timer_next   = timer;
    count_next   = count;
    rearm_next   = 1'b0;
    done_next    = 1'b0;
    timeout_next = 1'b0;
    if (bus.ctrl_abort) begin
      state_next = ST_IDLE;
      timer_next = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.ctrl_start) begin
            state_next = ST_SEARCH;
            rearm_next = 1'b1;
            count_next = '0;
            timer_next = '0;
          end
        end
        ST_SEARCH: begin
          if (!bus.sync_pre_sampling) begin
            state_next = ST_CAPTURE;
            timer_next = '0;
          end else if (timer == SEARCH_LAST) begin
            timeout_next = 1'b1;
            rearm_next   = 1'b1;
            count_next   = '0;
            timer_next   = '0;
          end else begin
            timer_next = timer + TIMER_W'(1);
          end
        end
        ST_CAPTURE: begin
          if (bus.sync_valid && bus.sync_endofpacket) begin
            count_next = count + 8'd1;
            timer_next = '0;
            if (count_next == FRAME_LEN) begin
              done_next  = 1'b1;
              state_next = ST_HOLDOFF;
            end else begin
              state_next = ST_SEARCH;
            end
          end else if (timer == CAPTURE_LAST) begin
            timeout_next = 1'b1;
            rearm_next   = 1'b1;
            count_next   = '0;
            timer_next   = '0;
            state_next   = ST_SEARCH;
          end else begin
            timer_next = timer + TIMER_W'(1);
          end
        end
        ST_HOLDOFF: begin
          if (timer == HOLDOFF_LAST) begin
            timer_next = '0;
            if (bus.ctrl_start) begin
              state_next = ST_SEARCH;
              rearm_next = 1'b1;
              count_next = '0;
            end else begin
              state_next = ST_IDLE;
            end
          end else begin
            timer_next = timer + TIMER_W'(1);
          end
        end
        default: begin
          state_next = ST_IDLE;
          timer_next = '0;
        end
      endcase
    end
  end

  assign bus.sync_enable  = sync_enable_q;
  assign bus.frame_active = frame_active_q;
  assign bus.sync_rearm   = sync_rearm_q;
  assign bus.frame_done   = frame_done_q;
  assign bus.timeout_err  = timeout_err_q;
  assign bus.symbol_count = count;
  assign bus.ctrl_state   = state;

`ifdef SYNC_CTRL_STATS_EN
  logic [15:0] stat_frames_q, stat_timeouts_q;

  // Saturating event counters, cleared only by reset.
  always_ff @(posedge clock_clk) begin
    if (!reset_reset_n) begin
      stat_frames_q   <= '0;
      stat_timeouts_q <= '0;
    end else begin
      if (done_next && !(&stat_frames_q))
        stat_frames_q <= stat_frames_q + 16'd1;
      if (timeout_next && !(&stat_timeouts_q))
        stat_timeouts_q <= stat_timeouts_q + 16'd1;
    end
  end

  assign bus.stat_frames   = stat_frames_q;
  assign bus.stat_timeouts = stat_timeouts_q;
`else
  assign bus.stat_frames   = '0;
  assign bus.stat_timeouts = '0;
`endif

endmodule

// File: tb/tb_ofdm_sync_controller.sv
// Bench for ofdm_sync_controller: two instances (2 and 6 symbols per frame) driven in lockstep
// and compared against a cycle model, plus a vector table and targeted corner sequences.
module tb_ofdm_sync_controller;

  localparam int ST    = 16;
  localparam int CT    = 8;
  localparam int HO    = 8;
  localparam int SPF_A = 2;
  localparam int SPF_B = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, abort = 1'b0, pre = 1'b1, valid = 1'b0, eop = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  ofdm_sync_controller_if bus_a ();
  ofdm_sync_controller_if bus_b ();

  assign bus_a.ctrl_start        = start;
  assign bus_a.ctrl_abort        = abort;
  assign bus_a.sync_pre_sampling = pre;
  assign bus_a.sync_valid        = valid;
  assign bus_a.sync_endofpacket  = eop;
  assign bus_b.ctrl_start        = start;
  assign bus_b.ctrl_abort        = abort;
  assign bus_b.sync_pre_sampling = pre;
  assign bus_b.sync_valid        = valid;
  assign bus_b.sync_endofpacket  = eop;

  ofdm_sync_controller #(
    .SYMBOLS_PER_FRAME(SPF_A), .SEARCH_TIMEOUT(ST), .CAPTURE_TIMEOUT(CT), .HOLDOFF_CYCLES(HO)
  ) dut_a (
    .clock_clk(clk), .reset_reset_n(rst_n), .bus(bus_a)
  );

  ofdm_sync_controller #(
    .SYMBOLS_PER_FRAME(SPF_B), .SEARCH_TIMEOUT(ST), .CAPTURE_TIMEOUT(CT), .HOLDOFF_CYCLES(HO)
  ) dut_b (
    .clock_clk(clk), .reset_reset_n(rst_n), .bus(bus_b)
  );

  // Phase numbering follows the required ctrl_state output values.
  typedef struct {
    int phase;
    int elapsed;
    int count;
    bit rearm;
    bit done;
    bit tmo;
    int frames;
    int timeouts;
  } model_t;

  typedef struct {
    bit start, abort, pre, valid, eop;
    int exp_state;
    int exp_count;
    bit exp_done, exp_rearm, exp_tmo;
  } vec_t;

  model_t m_a = '{default: 0};
  model_t m_b = '{default: 0};

  // elapsed = cycles already spent in the current phase; the Nth cycle is elapsed+1.
  function automatic model_t model_step(input model_t m, input bit r_n, input bit s, input bit ab,
                                        input bit p, input bit v, input bit e, input int spf);
    model_t n = m;
    n.rearm = 0;
    n.done  = 0;
    n.tmo   = 0;
    if (!r_n) begin
      n = '{default: 0};
      return n;
    end
    if (ab) begin
      n.phase   = 0;
      n.elapsed = 0;
      return n;
    end
    case (m.phase)
      0: if (s) begin
        n.phase = 1; n.elapsed = 0; n.count = 0; n.rearm = 1;
      end
      1: if (!p) begin
        n.phase = 2; n.elapsed = 0;
      end else if (m.elapsed + 1 == ST) begin
        n.tmo = 1; n.rearm = 1; n.count = 0; n.elapsed = 0;
      end else n.elapsed = m.elapsed + 1;
      2: if (v && e) begin
        n.count = m.count + 1;
        n.elapsed = 0;
        if (n.count == spf) begin n.done = 1; n.phase = 3; end
        else n.phase = 1;
      end else if (m.elapsed + 1 == CT) begin
        n.tmo = 1; n.rearm = 1; n.count = 0; n.phase = 1; n.elapsed = 0;
      end else n.elapsed = m.elapsed + 1;
      default: if (m.elapsed + 1 == HO) begin
        n.elapsed = 0;
        if (s) begin n.phase = 1; n.rearm = 1; n.count = 0; end
        else n.phase = 0;
      end else n.elapsed = m.elapsed + 1;
    endcase
    if (n.done && n.frames < 65535) n.frames++;
    if (n.tmo && n.timeouts < 65535) n.timeouts++;
    return n;
  endfunction

  task automatic check_output(input string name, input int actual, input int expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic check_dut(input string tag, input model_t m, input logic en, input logic fa,
                           input logic rearm, input logic [7:0] cnt, input logic done,
                           input logic tmo, input logic [2:0] st, input logic [15:0] sf,
                           input logic [15:0] stt);
    bit busy;
    busy = (m.phase == 1) || (m.phase == 2);
    check_output({tag, ".ctrl_state"}, int'(st), m.phase);
    check_output({tag, ".sync_enable"}, int'(en), int'(busy));
    check_output({tag, ".frame_active"}, int'(fa), int'(busy));
    check_output({tag, ".sync_rearm"}, int'(rearm), int'(m.rearm));
    check_output({tag, ".symbol_count"}, int'(cnt), m.count);
    check_output({tag, ".frame_done"}, int'(done), int'(m.done));
    check_output({tag, ".timeout_err"}, int'(tmo), int'(m.tmo));
`ifdef SYNC_CTRL_STATS_EN
    check_output({tag, ".stat_frames"}, int'(sf), m.frames);
    check_output({tag, ".stat_timeouts"}, int'(stt), m.timeouts);
`else
    check_output({tag, ".stat_frames"}, int'(sf), 0);
    check_output({tag, ".stat_timeouts"}, int'(stt), 0);
`endif
  endtask

  // One clock: drive inputs, take the edge, advance both models, compare both DUTs.
  task automatic apply_stimulus(input bit r_n, input bit s, input bit ab, input bit p,
                                input bit v, input bit e);
    rst_n = r_n; start = s; abort = ab; pre = p; valid = v; eop = e;
    @(posedge clk);
    #1;
    m_a = model_step(m_a, r_n, s, ab, p, v, e, SPF_A);
    m_b = model_step(m_b, r_n, s, ab, p, v, e, SPF_B);
    check_dut("dut_a", m_a, bus_a.sync_enable, bus_a.frame_active, bus_a.sync_rearm,
              bus_a.symbol_count, bus_a.frame_done, bus_a.timeout_err, bus_a.ctrl_state,
              bus_a.stat_frames, bus_a.stat_timeouts);
    check_dut("dut_b", m_b, bus_b.sync_enable, bus_b.frame_active, bus_b.sync_rearm,
              bus_b.symbol_count, bus_b.frame_done, bus_b.timeout_err, bus_b.ctrl_state,
              bus_b.stat_frames, bus_b.stat_timeouts);
  endtask

  vec_t vecs[14];

  initial begin
    // Full two-symbol frame on dut_a, then eight HOLDOFF cycles and back to IDLE.
    vecs[0]  = '{1, 0, 1, 0, 0, 1, 0, 0, 1, 0};
    vecs[1]  = '{0, 0, 0, 0, 0, 2, 0, 0, 0, 0};
    vecs[2]  = '{0, 0, 1, 1, 1, 1, 1, 0, 0, 0};
    vecs[3]  = '{0, 0, 0, 0, 0, 2, 1, 0, 0, 0};
    vecs[4]  = '{0, 0, 1, 1, 1, 3, 2, 1, 0, 0};
    for (int i = 5; i < 12; i++) vecs[i] = '{0, 0, 1, 0, 0, 3, 2, 0, 0, 0};
    vecs[12] = '{0, 0, 1, 0, 0, 0, 2, 0, 0, 0};
    vecs[13] = '{0, 0, 1, 0, 0, 0, 2, 0, 0, 0};

    apply_stimulus(0, 0, 0, 1, 0, 0);
    apply_stimulus(0, 1, 0, 1, 1, 1);
    check_output("reset.ctrl_state", int'(bus_a.ctrl_state), 0);
    check_output("reset.symbol_count", int'(bus_a.symbol_count), 0);
    check_output("reset.sync_enable", int'(bus_a.sync_enable), 0);

    for (int i = 0; i < 14; i++) begin
      apply_stimulus(1, vecs[i].start, vecs[i].abort, vecs[i].pre, vecs[i].valid, vecs[i].eop);
      check_output($sformatf("vec%0d.state", i), int'(bus_a.ctrl_state), vecs[i].exp_state);
      check_output($sformatf("vec%0d.count", i), int'(bus_a.symbol_count), vecs[i].exp_count);
      check_output($sformatf("vec%0d.done", i), int'(bus_a.frame_done), int'(vecs[i].exp_done));
      check_output($sformatf("vec%0d.rearm", i), int'(bus_a.sync_rearm), int'(vecs[i].exp_rearm));
      check_output($sformatf("vec%0d.tmo", i), int'(bus_a.timeout_err), int'(vecs[i].exp_tmo));
    end

    // SEARCH timeout on the 16th SEARCH cycle; state stays SEARCH.
    apply_stimulus(0, 0, 0, 1, 0, 0);
    apply_stimulus(1, 1, 0, 1, 0, 0);
    for (int i = 1; i <= ST; i++) begin
      apply_stimulus(1, 0, 0, 1, 0, 0);
      check_output($sformatf("search_tmo.c%0d", i), int'(bus_a.timeout_err), int'(i == ST));
    end
    check_output("search_tmo.rearm", int'(bus_a.sync_rearm), 1);
    check_output("search_tmo.state", int'(bus_a.ctrl_state), 1);
`ifdef SYNC_CTRL_STATS_EN
    check_output("search_tmo.stat_timeouts", int'(bus_a.stat_timeouts), 1);
`endif

    // CAPTURE timeout after one completed symbol clears the count.
    apply_stimulus(1, 0, 0, 0, 0, 0);
    apply_stimulus(1, 0, 0, 1, 1, 1);
    check_output("cap_tmo.pre_count", int'(bus_a.symbol_count), 1);
    apply_stimulus(1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= CT; i++) begin
      apply_stimulus(1, 0, 0, 1, 0, 0);
      check_output($sformatf("cap_tmo.c%0d", i), int'(bus_a.timeout_err), int'(i == CT));
    end
    check_output("cap_tmo.count", int'(bus_a.symbol_count), 0);
    check_output("cap_tmo.state", int'(bus_a.ctrl_state), 1);

    // End-of-packet on the exact CAPTURE timeout cycle wins.
    apply_stimulus(1, 0, 0, 0, 0, 0);
    for (int i = 1; i < CT; i++) apply_stimulus(1, 0, 0, 1, 0, 0);
    apply_stimulus(1, 0, 0, 1, 1, 1);
    check_output("eop_on_tmo.count", int'(bus_a.symbol_count), 1);
    check_output("eop_on_tmo.tmo", int'(bus_a.timeout_err), 0);
    check_output("eop_on_tmo.state", int'(bus_a.ctrl_state), 1);

    // Abort together with the frame-completing eop: IDLE, no pulse, count held.
    apply_stimulus(1, 0, 0, 0, 0, 0);
    apply_stimulus(1, 1, 1, 1, 1, 1);
    check_output("abort_eop.state", int'(bus_a.ctrl_state), 0);
    check_output("abort_eop.done", int'(bus_a.frame_done), 0);
    check_output("abort_eop.count", int'(bus_a.symbol_count), 1);

    // Reset in the middle of CAPTURE with five symbols on dut_b.
    apply_stimulus(0, 0, 0, 1, 0, 0);
    apply_stimulus(1, 1, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1, 0, 0, 0, 0, 0);
      apply_stimulus(1, 0, 0, 1, 1, 1);
    end
    apply_stimulus(1, 0, 0, 0, 0, 0);
    check_output("mid_reset.pre_count", int'(bus_b.symbol_count), 5);
    check_output("mid_reset.pre_state", int'(bus_b.ctrl_state), 2);
    apply_stimulus(0, 0, 0, 0, 1, 1);
    check_output("mid_reset.state", int'(bus_b.ctrl_state), 0);
    check_output("mid_reset.count", int'(bus_b.symbol_count), 0);
    check_output("mid_reset.enable", int'(bus_b.sync_enable), 0);
    check_output("mid_reset.active", int'(bus_b.frame_active), 0);
    check_output("mid_reset.pulses",
                 int'(bus_b.frame_done | bus_b.timeout_err | bus_b.sync_rearm), 0);
    check_output("mid_reset.stats", int'(bus_b.stat_frames | bus_b.stat_timeouts), 0);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      apply_stimulus($urandom_range(0, 299) != 0, $urandom_range(0, 3) == 0,
                     $urandom_range(0, 63) == 0, $urandom_range(0, 2) != 0,
                     $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
